// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// Combinational lookup from the fetch PC; registered training from the resolve stage.
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] if_pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_npc_o,
    input  logic              flush_i,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    output logic [31:0]       mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [CNT_W-1:0]   cnt_d    [ENTRIES];
    logic [31:0]        mispred_q, mispred_d;

    // Lookup path
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx = if_pc_i[IDX_W+1:2];
    assign lk_tag = if_pc_i[ADDR_W-1:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign pred_taken_o  = lk_hit && cnt_q[lk_idx][CNT_W-1];
    assign pred_npc_o    = pred_taken_o ? target_q[lk_idx] : if_pc_i + ADDR_W'(4);
    assign mispred_cnt_o = mispred_q;

    // Update path
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             unused_pc_lsbs;

    assign up_idx         = upd_pc_i[IDX_W+1:2];
    assign up_tag         = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign up_hit         = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign unused_pc_lsbs = ^upd_pc_i[1:0];

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        mispred_d = mispred_q;

        // The mispredict count sees every resolved branch, even one a flush discards.
        if (upd_valid_i && (upd_pred_taken_i != upd_taken_i) && (mispred_q != 32'hFFFF_FFFF))
            mispred_d = mispred_q + 32'd1;

        if (flush_i) begin
            valid_d = '0;
        end else if (upd_valid_i) begin
            if (up_hit) begin
                if (upd_taken_i) begin
                    target_d[up_idx] = upd_target_i;
                    if (cnt_q[up_idx] != CNT_MAX)
                        cnt_d[up_idx] = cnt_q[up_idx] + CNT_W'(1);
                end else if (cnt_q[up_idx] != '0) begin
                    cnt_d[up_idx] = cnt_q[up_idx] - CNT_W'(1);
                end
            end else if (upd_taken_i) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target_i;
                cnt_d[up_idx]    = CNT_WEAK_T;
            end
        end
    end

    // NOTE: the table is flop-based, not RAM, so every entry can take its reset value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q   <= '0;
            mispred_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WEAK_NT;
            end
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            mispred_q <= mispred_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized plus directed bench for branch_predictor; expectations come from a
// behavioural BTB model and are checked by a decoupled scoreboard monitor.
module tb_branch_predictor;

    localparam int ADDR_W  = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [ADDR_W-1:0] if_pc_i = '0;
    logic              pred_taken_o;
    logic [ADDR_W-1:0] pred_npc_o;
    logic              flush_i = 1'b0;
    logic              upd_valid_i = 1'b0;
    logic [ADDR_W-1:0] upd_pc_i = '0;
    logic              upd_taken_i = 1'b0;
    logic [ADDR_W-1:0] upd_target_i = '0;
    logic              upd_pred_taken_i = 1'b0;
    logic [31:0]       mispred_cnt_o;

    branch_predictor #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .if_pc_i          (if_pc_i),
        .pred_taken_o     (pred_taken_o),
        .pred_npc_o       (pred_npc_o),
        .flush_i          (flush_i),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_pred_taken_i (upd_pred_taken_i),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference model: a table of entries with an integer confidence counter.
    typedef struct {
        bit          valid;
        longint      tag;
        logic [31:0] target;
        int          cnt;
    } entry_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] npc;
        logic [31:0] mis;
    } expect_t;

    entry_t  model [ENTRIES];
    longint  model_mis;
    expect_t sb_q[$];

    localparam int CNT_TOP  = (1 << CNT_W) - 1;
    localparam int CNT_HALF = 1 << (CNT_W - 1);

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic longint tag_of(input logic [31:0] pc);
        return longint'(pc) / (4 * ENTRIES);
    endfunction

    task automatic model_reset();
        model_mis = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            model[i].valid  = 0;
            model[i].tag    = 0;
            model[i].target = '0;
            model[i].cnt    = CNT_HALF - 1;
        end
    endtask

    task automatic push_expect(input string name, input logic [31:0] pc);
        expect_t e;
        int      i;
        bit      hit;
        i = idx_of(pc);
        hit = model[i].valid && (model[i].tag == tag_of(pc));
        e.name  = name;
        e.pc    = pc;
        e.taken = hit && (model[i].cnt >= CNT_HALF);
        e.npc   = e.taken ? model[i].target : pc + 32'd4;
        e.mis   = model_mis[31:0];
        sb_q.push_back(e);
    endtask

    task automatic model_update(input logic fl, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utg, input logic upt);
        int i;
        bit hit;
        if (uv && (upt != ut) && (model_mis < 64'hFFFF_FFFF)) model_mis++;
        if (fl) begin
            for (int k = 0; k < ENTRIES; k++) model[k].valid = 0;
        end else if (uv) begin
            i = idx_of(upc);
            hit = model[i].valid && (model[i].tag == tag_of(upc));
            if (hit && ut) begin
                model[i].cnt    = (model[i].cnt + 1 > CNT_TOP) ? CNT_TOP : model[i].cnt + 1;
                model[i].target = utg;
            end else if (hit) begin
                model[i].cnt = (model[i].cnt - 1 < 0) ? 0 : model[i].cnt - 1;
            end else if (ut) begin
                model[i].valid  = 1;
                model[i].tag    = tag_of(upc);
                model[i].target = utg;
                model[i].cnt    = CNT_HALF;
            end
        end
    endtask

    // One clock of stimulus: drive after the edge, record the expected lookup, advance the model.
    task automatic step(input string name, input logic [31:0] pc, input logic fl, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                        input logic upt);
        @(posedge clk_i);
        #1;
        if_pc_i          = pc;
        flush_i          = fl;
        upd_valid_i      = uv;
        upd_pc_i         = upc;
        upd_taken_i      = ut;
        upd_target_i     = utg;
        upd_pred_taken_i = upt;
        push_expect(name, pc);
        model_update(fl, uv, upc, ut, utg, upt);
    endtask

    task automatic lookup(input string name, input logic [31:0] pc);
        step(name, pc, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic train(input string name, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utg, input logic upt);
        step(name, upc, 1'b0, 1'b1, upc, ut, utg, upt);
    endtask

    // Reset asserted between edges, with an update pending that must be discarded.
    task automatic reset_pulse(input string name, input logic [31:0] pc);
        @(posedge clk_i);
        #1;
        rst_i            = 1'b0;
        if_pc_i          = pc;
        flush_i          = 1'b0;
        upd_valid_i      = 1'b1;
        upd_pc_i         = pc;
        upd_taken_i      = 1'b1;
        upd_target_i     = 32'hDEAD_BEE0;
        upd_pred_taken_i = 1'b0;
        model_reset();
        push_expect(name, pc);
        @(posedge clk_i);
        #1;
        push_expect({name, "_held"}, pc);
        @(posedge clk_i);
        #1;
        rst_i       = 1'b1;
        upd_valid_i = 1'b0;
        push_expect({name, "_released"}, pc);
    endtask

    // Monitor: the outputs are combinational, so each cycle's response is taken at the falling edge.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk_i);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".taken"},   32'(pred_taken_o), 32'(e.taken));
                check({e.name, ".npc"},     pred_npc_o,        e.npc);
                check({e.name, ".mispred"}, mispred_cnt_o,     e.mis);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc, tg;
        int          wait_cycles;

        model_reset();
        reset_pulse("reset", 32'h100);

        // Allocate, then predict taken; mispredict counted
        train("alloc", 32'h100, 1'b1, 32'h200, 1'b0);
        lookup("hit_200", 32'h100);

        // Counter walks down, saturates at 0, then up to 3, one decrement still taken
        repeat (3) train("dec", 32'h100, 1'b0, 32'h0, 1'b1);
        lookup("sat_low", 32'h100);
        repeat (4) train("inc", 32'h100, 1'b1, 32'h200, 1'b0);
        train("dec_once", 32'h100, 1'b0, 32'h0, 1'b1);
        lookup("still_taken", 32'h100);

        // Same index, different tag
        train("alias", 32'h140, 1'b1, 32'h480, 1'b1);
        lookup("alias_old", 32'h100);
        lookup("alias_new", 32'h140);

        // Flush wins over a same-cycle allocation
        train("pre_flush", 32'h104, 1'b1, 32'h600, 1'b0);
        step("flush", 32'h140, 1'b1, 1'b1, 32'h300, 1'b1, 32'h700, 1'b0);
        lookup("post_flush_140", 32'h140);
        lookup("post_flush_300", 32'h300);
        lookup("post_flush_104", 32'h104);

        // Same-cycle lookup and update: lookup sees pre-update contents
        step("no_bypass", 32'h220, 1'b0, 1'b1, 32'h220, 1'b1, 32'h900, 1'b0);
        lookup("after_alloc", 32'h220);

        // Wrap-around entry at the top of the address space
        train("top_alloc", 32'hFFFF_FFFC, 1'b1, 32'h0000_1000, 1'b0);
        lookup("top_hit", 32'hFFFF_FFFC);

        // Reset mid-run after training
        reset_pulse("mid_reset", 32'hFFFF_FFFC);
        lookup("wrap", 32'hFFFF_FFFC);

        // Random traffic over a few tags so hits, aliasing and saturation all occur
        for (int n = 0; n < 600; n++) begin
            logic [31:0] tags [4];
            logic [31:0] lpc;
            tags[0] = 32'h0;
            tags[1] = 32'h1;
            tags[2] = 32'h2;
            tags[3] = 32'h03FF_FFFF;
            pc  = {tags[$urandom_range(0, 3)][25:0], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            lpc = {tags[$urandom_range(0, 3)][25:0], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            tg  = $urandom;
            step("rand", lpc, ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                 pc, 1'($urandom), tg, 1'($urandom));
        end
        lookup("final", 32'h100);

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk_i);
            wait_cycles++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
